// File: rtl/cipher_ctrl_pkg.sv
// Shared types and helpers for the cipher stream sequencer.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package cipher_ctrl_pkg;

  // Datapath stages tracked: xor reg, sbox reg, pbox/output reg.
  localparam int PIPE_LAT = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Per-frame seed: session seed mixed with the completed-frame count so
  // every frame of a session starts from a different keystream.
  function automatic logic [7:0] seed_mix(input logic [7:0] s, input logic [7:0] f);
    return s ^ f;
  endfunction

endpackage

// File: rtl/cipher_stream_ctrl_if.sv
// Byte handshake bundle between source, controller and consumer.
// Latency: wires only.
// Backpressure: in_ready / out_ready carry it in each direction.
interface cipher_stream_ctrl_if;
  logic in_valid;
  logic in_ready;
  logic out_valid;
  logic out_ready;

  // Environment side: byte source and encrypted-byte consumer.
  modport master (output in_valid, output out_ready, input in_ready, input out_valid);
  // Controller side.
  modport slave  (input in_valid, input out_ready, output in_ready, output out_valid);
endinterface

// File: rtl/pipe_vld_tracker.sv
// Valid shadow of the datapath stages, plus stall and out_valid derivation.
// Latency: a bit entering stage 0 reaches the last stage PIPE_LAT-1 edges later.
// Backpressure: whole register holds while the last stage is valid and not taken.
module pipe_vld_tracker
  import cipher_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                shift_in,
  input  logic                out_ready,
  output logic [PIPE_LAT-1:0] stage_vld,
  output logic                stall,
  output logic                out_valid
);

  assign out_valid = stage_vld[PIPE_LAT-1];
  assign stall     = out_valid & ~out_ready;

  // Shift accepted-byte markers down the pipe; freeze everything on stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_vld <= '0;
    end else if (!stall) begin
      stage_vld <= {stage_vld[PIPE_LAT-2:0], shift_in};
    end
  end

endmodule

// File: rtl/cipher_stream_ctrl.sv
// Sequencer for the byte-serial cipher: LFSR load/advance, stage enables, framing.
// Latency: byte accepted in cycle c is out_valid in cycle c+PIPE_LAT.
// Backpressure: out_ready low with a valid output stalls the pipe and drops in_ready.
module cipher_stream_ctrl
  import cipher_ctrl_pkg::*;
#(
  parameter int FRAME_LEN = 256,
  parameter int CNT_W     = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic [7:0]            seed,
  cipher_stream_ctrl_if.slave   strm,
  output logic                  lfsr_load,
  output logic [7:0]            lfsr_seed,
  output logic                  lfsr_adv,
  output logic                  pipe_en,
  output logic                  frame_done,
  output logic [7:0]            frame_cnt,
  output logic                  busy
);

  state_t              state;
  logic [7:0]          seed_reg;
  logic [CNT_W-1:0]    byte_cnt;
  logic                stop_pend;
  logic [PIPE_LAT-1:0] stage_vld;
  logic                stall;
  logic                accept;
  logic                out_fire;
  logic                last_out;
  logic                frame_full;

  pipe_vld_tracker u_trk (
    .clk       (clk),
    .rst       (rst),
    .shift_in  (accept),
    .out_ready (strm.out_ready),
    .stage_vld (stage_vld),
    .stall     (stall),
    .out_valid (strm.out_valid)
  );

  assign strm.in_ready = (state == RUN) & ~stall;
  assign accept        = strm.in_valid & strm.in_ready;
  assign lfsr_adv      = accept;
  // Gated by reset so the enable is low while held in reset and high as soon as it lifts.
  assign pipe_en       = rst & ~stall;
  assign out_fire      = strm.out_valid & strm.out_ready;
  // Only the output stage holds a byte: this output is the frame's last.
  assign last_out      = (stage_vld[PIPE_LAT-2:0] == '0);
  // No accepts happen in DRAIN, so the last byte out while draining closes the frame;
  // an empty frame (stop before any accept) never produces a pulse.
  assign frame_done    = (state == DRAIN) & out_fire & last_out & (byte_cnt != '0);
  assign frame_full    = accept & (byte_cnt == CNT_W'(FRAME_LEN - 1));

  // Session FSM with registered LFSR load/seed and busy, plus byte/frame counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      seed_reg  <= '0;
      byte_cnt  <= '0;
      frame_cnt <= '0;
      stop_pend <= 1'b0;
      lfsr_load <= 1'b0;
      lfsr_seed <= '0;
      busy      <= 1'b0;
    end else begin
      lfsr_load <= 1'b0;
      lfsr_seed <= '0;
      if (accept)     byte_cnt  <= byte_cnt + 1'b1;
      if (frame_done) frame_cnt <= frame_cnt + 8'd1;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= LOAD;
            seed_reg  <= seed;
            byte_cnt  <= '0;
            frame_cnt <= '0;
            stop_pend <= 1'b0;
            lfsr_load <= 1'b1;
            lfsr_seed <= seed_mix(seed, 8'd0);
            busy      <= 1'b1;
          end
        end
        LOAD: begin
          state <= RUN;
          if (stop) stop_pend <= 1'b1;
        end
        RUN: begin
          if (frame_full || stop || stop_pend) begin
            state <= DRAIN;
            if (stop) stop_pend <= 1'b1;
          end
        end
        DRAIN: begin
          if (stop) stop_pend <= 1'b1;
          if (stage_vld == '0) begin
            byte_cnt <= '0;
            if (stop_pend || stop) begin
              state     <= IDLE;
              stop_pend <= 1'b0;
              busy      <= 1'b0;
            end else begin
              // frame_cnt already counts the frame just finished.
              state     <= LOAD;
              lfsr_load <= 1'b1;
              lfsr_seed <= seed_mix(seed_reg, frame_cnt);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cipher_stream_ctrl.sv
// Directed bench for the cipher stream sequencer, FRAME_LEN=4.
// Latency: cycle-indexed tables relative to the first RUN cycle.
// Backpressure: driven directly on out_ready.
module tb_cipher_stream_ctrl;

  localparam int FL = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] seed = 8'h00;
  logic       lfsr_load, lfsr_adv, pipe_en, frame_done, busy;
  logic [7:0] lfsr_seed, frame_cnt;

  int checks = 0;
  int errors = 0;
  int n_accept = 0, n_out = 0, n_adv = 0, n_load = 0, n_fdone = 0;

  cipher_stream_ctrl_if strm ();

  cipher_stream_ctrl #(.FRAME_LEN(FL), .CNT_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .seed       (seed),
    .strm       (strm),
    .lfsr_load  (lfsr_load),
    .lfsr_seed  (lfsr_seed),
    .lfsr_adv   (lfsr_adv),
    .pipe_en    (pipe_en),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Every-cycle invariants and event counters, sampled mid-cycle.
  always @(negedge clk) begin
    checks++;
    if (lfsr_adv && lfsr_load) begin
      errors++;
      $display("FAIL adv_with_load t=%0t lfsr_adv=%0b lfsr_load=%0b want not both", $time, lfsr_adv, lfsr_load);
    end
    checks++;
    if (lfsr_adv !== (strm.in_valid & strm.in_ready)) begin
      errors++;
      $display("FAIL adv_eq_accept t=%0t lfsr_adv=%0b want %0b", $time, lfsr_adv, strm.in_valid & strm.in_ready);
    end
    if (strm.in_valid && strm.in_ready) n_accept++;
    if (strm.out_valid && strm.out_ready) n_out++;
    if (lfsr_adv) n_adv++;
    if (lfsr_load) n_load++;
    if (frame_done) n_fdone++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b0; start = 1'b0; stop = 1'b0; seed = 8'h00;
    strm.in_valid = 1'b0; strm.out_ready = 1'b1;
    tick(); tick();
    rst = 1'b1;
    tick();
    n_accept = 0; n_out = 0; n_adv = 0; n_load = 0; n_fdone = 0;
  endtask

  // Pulse start for one cycle; returns at the start of the LOAD cycle.
  task automatic begin_session(input logic [7:0] s);
    start = 1'b1; seed = s;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; strm.in_valid = 1'b1; strm.out_ready = 1'b1;
    tick(); tick(); settle();
    checks++;
    if ({strm.in_ready, strm.out_valid, lfsr_load, lfsr_adv, pipe_en, frame_done, busy} !== 7'b0 ||
        lfsr_seed !== 8'h00 || frame_cnt !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs rdy=%0b ov=%0b ld=%0b adv=%0b en=%0b fd=%0b busy=%0b seed=%0h fc=%0h want all 0",
               strm.in_ready, strm.out_valid, lfsr_load, lfsr_adv, pipe_en, frame_done, busy, lfsr_seed, frame_cnt);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({pipe_en, strm.in_ready, busy, strm.out_valid} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_exit en/rdy/busy/ov=%b want 1000", {pipe_en, strm.in_ready, busy, strm.out_valid});
    end
    strm.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_frame();
    logic e;
    do_reset();
    begin_session(8'h5A);
    settle();
    checks++;
    if ({lfsr_load, lfsr_seed, strm.in_ready} !== {1'b1, 8'h5A, 1'b0}) begin
      errors++;
      $display("FAIL frame_load ld=%0b seed=%0h rdy=%0b want 1 5a 0", lfsr_load, lfsr_seed, strm.in_ready);
    end
    tick();
    for (int c = 0; c < 10; c++) begin
      strm.in_valid = (c < 4);
      settle();
      e = (c >= 3 && c <= 6);
      checks++;
      if (strm.out_valid !== e) begin errors++; $display("FAIL frame_ov c=%0d got %0b want %0b", c, strm.out_valid, e); end
      e = (c == 6);
      checks++;
      if (frame_done !== e) begin errors++; $display("FAIL frame_done c=%0d got %0b want %0b", c, frame_done, e); end
      e = (c < 4 || c == 9);
      checks++;
      if (strm.in_ready !== e) begin errors++; $display("FAIL frame_rdy c=%0d got %0b want %0b", c, strm.in_ready, e); end
      e = (c == 8);
      checks++;
      if (lfsr_load !== e) begin errors++; $display("FAIL frame_reload c=%0d got %0b want %0b", c, lfsr_load, e); end
      if (c == 8) begin
        checks++;
        if (lfsr_seed !== 8'h5B) begin errors++; $display("FAIL frame_reseed got %0h want 5b", lfsr_seed); end
      end
      tick();
    end
    strm.in_valid = 1'b0;
    checks++;
    if (frame_cnt !== 8'd1 || n_accept != 4 || n_adv != 4 || n_out != 4 || n_fdone != 1 || n_load != 2) begin
      errors++;
      $display("FAIL frame_counts fc=%0d acc=%0d adv=%0d out=%0d fd=%0d ld=%0d want 1 4 4 4 1 2",
               frame_cnt, n_accept, n_adv, n_out, n_fdone, n_load);
    end
  endtask

  task automatic test_stall();
    logic e;
    do_reset();
    begin_session(8'h11);
    tick();
    for (int c = 0; c < 12; c++) begin
      strm.in_valid  = (c < 8);
      strm.out_ready = !(c >= 3 && c <= 7);
      settle();
      e = (c >= 3 && c <= 10);
      checks++;
      if (strm.out_valid !== e) begin errors++; $display("FAIL stall_ov c=%0d got %0b want %0b", c, strm.out_valid, e); end
      e = !(c >= 3 && c <= 7);
      checks++;
      if (pipe_en !== e) begin errors++; $display("FAIL stall_en c=%0d got %0b want %0b", c, pipe_en, e); end
      e = (c < 3 || c >= 8);
      checks++;
      if (strm.in_ready !== e) begin errors++; $display("FAIL stall_rdy c=%0d got %0b want %0b", c, strm.in_ready, e); end
      e = (c < 3);
      checks++;
      if (lfsr_adv !== e) begin errors++; $display("FAIL stall_adv c=%0d got %0b want %0b", c, lfsr_adv, e); end
      tick();
    end
    strm.in_valid = 1'b0; strm.out_ready = 1'b1;
    checks++;
    if (n_accept != 3 || n_out != 3 || n_fdone != 0) begin
      errors++;
      $display("FAIL stall_counts acc=%0d out=%0d fd=%0d want 3 3 0", n_accept, n_out, n_fdone);
    end
  endtask

  task automatic test_stop_short();
    logic e;
    do_reset();
    begin_session(8'h21);
    tick();
    for (int c = 0; c < 8; c++) begin
      strm.in_valid = (c < 2);
      stop = (c == 2);
      settle();
      e = (c == 3 || c == 4);
      checks++;
      if (strm.out_valid !== e) begin errors++; $display("FAIL short_ov c=%0d got %0b want %0b", c, strm.out_valid, e); end
      e = (c == 4);
      checks++;
      if (frame_done !== e) begin errors++; $display("FAIL short_done c=%0d got %0b want %0b", c, frame_done, e); end
      e = (c < 6);
      checks++;
      if (busy !== e) begin errors++; $display("FAIL short_busy c=%0d got %0b want %0b", c, busy, e); end
      tick();
    end
    stop = 1'b0;
    checks++;
    if (frame_cnt !== 8'd1 || n_fdone != 1 || n_load != 1 || n_out != 2 || n_accept != 2) begin
      errors++;
      $display("FAIL short_counts fc=%0d fd=%0d ld=%0d out=%0d acc=%0d want 1 1 1 2 2",
               frame_cnt, n_fdone, n_load, n_out, n_accept);
    end
  endtask

  task automatic test_stop_last();
    logic e;
    do_reset();
    begin_session(8'h40);
    tick();
    for (int c = 0; c < 10; c++) begin
      strm.in_valid = (c < 4);
      stop = (c == 3);
      settle();
      e = (c == 6);
      checks++;
      if (frame_done !== e) begin errors++; $display("FAIL last_done c=%0d got %0b want %0b", c, frame_done, e); end
      e = (c < 8);
      checks++;
      if (busy !== e) begin errors++; $display("FAIL last_busy c=%0d got %0b want %0b", c, busy, e); end
      checks++;
      if (lfsr_load !== 1'b0) begin errors++; $display("FAIL last_noload c=%0d got %0b want 0", c, lfsr_load); end
      tick();
    end
    stop = 1'b0;
    checks++;
    if (frame_cnt !== 8'd1 || n_fdone != 1 || n_load != 1 || n_out != 4 || n_accept != 4) begin
      errors++;
      $display("FAIL last_counts fc=%0d fd=%0d ld=%0d out=%0d acc=%0d want 1 1 1 4 4",
               frame_cnt, n_fdone, n_load, n_out, n_accept);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    begin_session(8'hC3);
    tick();
    strm.in_valid = 1'b1;
    tick(); tick();
    strm.in_valid = 1'b0;
    settle();
    rst = 1'b0;
    strm.in_valid = 1'b1;
    #1;
    checks++;
    if ({strm.in_ready, strm.out_valid, lfsr_load, lfsr_adv, pipe_en, frame_done, busy} !== 7'b0 ||
        lfsr_seed !== 8'h00 || frame_cnt !== 8'h00) begin
      errors++;
      $display("FAIL midrst_outputs rdy=%0b ov=%0b ld=%0b adv=%0b en=%0b fd=%0b busy=%0b seed=%0h fc=%0h want all 0",
               strm.in_ready, strm.out_valid, lfsr_load, lfsr_adv, pipe_en, frame_done, busy, lfsr_seed, frame_cnt);
    end
    tick(); tick();
    rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      settle();
      checks++;
      if ({busy, strm.out_valid, strm.in_ready, pipe_en} !== 4'b0001 || frame_cnt !== 8'h00) begin
        errors++;
        $display("FAIL midrst_after c=%0d busy/ov/rdy/en=%b fc=%0h want 0001 00",
                 c, {busy, strm.out_valid, strm.in_ready, pipe_en}, frame_cnt);
      end
      tick();
    end
    strm.in_valid = 1'b0;
    checks++;
    if (n_fdone != 0 || n_out != 0) begin
      errors++;
      $display("FAIL midrst_counts fd=%0d out=%0d want 0 0", n_fdone, n_out);
    end
  endtask

  task automatic test_start_ignored();
    logic e;
    do_reset();
    strm.in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      settle();
      checks++;
      if (strm.in_ready !== 1'b0) begin errors++; $display("FAIL idle_rdy c=%0d got %0b want 0", c, strm.in_ready); end
      tick();
    end
    begin_session(8'h33);
    settle();
    checks++;
    if ({strm.in_ready, lfsr_seed} !== {1'b0, 8'h33}) begin
      errors++;
      $display("FAIL ign_load rdy=%0b seed=%0h want 0 33", strm.in_ready, lfsr_seed);
    end
    tick();
    for (int c = 0; c < 10; c++) begin
      strm.in_valid = (c < 4);
      start = (c == 1);
      seed  = (c == 1) ? 8'h77 : 8'h00;
      settle();
      e = (c < 4 || c == 9);
      checks++;
      if (strm.in_ready !== e) begin errors++; $display("FAIL ign_rdy c=%0d got %0b want %0b", c, strm.in_ready, e); end
      e = (c == 8);
      checks++;
      if (lfsr_load !== e) begin errors++; $display("FAIL ign_load c=%0d got %0b want %0b", c, lfsr_load, e); end
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL ign_busy c=%0d got %0b want 1", c, busy); end
      if (c == 8) begin
        checks++;
        if (lfsr_seed !== 8'h32) begin errors++; $display("FAIL ign_reseed got %0h want 32", lfsr_seed); end
      end
      tick();
    end
    start = 1'b0; strm.in_valid = 1'b0;
    checks++;
    if (n_load != 2 || n_accept != 4 || n_out != 4) begin
      errors++;
      $display("FAIL ign_counts ld=%0d acc=%0d out=%0d want 2 4 4", n_load, n_accept, n_out);
    end
  endtask

  initial begin
    strm.in_valid  = 1'b0;
    strm.out_ready = 1'b1;
    test_reset();
    test_frame();
    test_stall();
    test_stop_short();
    test_stop_last();
    test_reset_mid();
    test_start_ignored();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
